color_detect_proc: RTL and testbench
====================================

Name: color_detect_proc

Overview:
- Image-processing stage directly downstream of the frame buffer's processing read port.
- On a start pulse it scans the stored 160x120 RGB444 frame, one pixel per clock, and classifies each pixel as red, green, blue or neither.
- It reports per-colour pixel counts and a dominant-colour code with a busy/done handshake.
- Results are read by the SoC CPU register wrapper; the VGA read path is untouched.

Parameters:
- AW, 15: address width of the buffer processing port.
- DW, 12: pixel width. RGB444: R=[11:8], G=[7:4], B=[3:0].
- IMA_SIZE, 19200: number of pixels scanned (160*120), at addresses 0..IMA_SIZE-1.
- TH_HI, 4'd8: a channel is "strong" if it is >= TH_HI.
- TH_LO, 4'd5: a channel is "weak" if it is < TH_LO.
- MIN_PIX, 1920: minimum count for a colour to be declared dominant (10% of the frame).
- PARK_ADDR, 15'h7FFF: address driven while not scanning; this location holds black.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- init, in, 1: start request, sampled at posedge.
- proc_addr_in, out, AW: pixel address to the buffer processing port.
- proc_data_in, in, DW: pixel data from the buffer. This path is combinational in the address.
- busy, out, 1: high while a scan is in progress.
- done, out, 1: one-cycle pulse when results are valid.
- color, out, 2: dominant colour. 00=none, 01=red, 10=green, 11=blue.
- cnt_r, out, 15: red pixel count of the last completed scan.
- cnt_g, out, 15: green pixel count of the last completed scan.
- cnt_b, out, 15: blue pixel count of the last completed scan.

Behaviour:
- All outputs and state are registered.
- Reset (async, immediate, any time, including mid-scan):
  - state=IDLE
  - proc_addr_in=PARK_ADDR
  - busy=0, done=0, color=00
  - cnt_r=cnt_g=cnt_b=0
  - internal accumulators=0
  - The scan is abandoned and no done pulse is produced.
- Pixel classification (combinational on proc_data_in):
  - red = R>=TH_HI and G<TH_LO and B<TH_LO. Green and blue are defined symmetrically.
  - At most one class is true per pixel; all other pixels are ignored.
- FSM states: IDLE, SCAN, DECIDE, DONE.
- IDLE:
  - proc_addr_in=PARK_ADDR.
  - If init=1 at edge E0: go to SCAN, proc_addr_in<=0, clear accumulators, busy<=1.
- SCAN:
  - At each edge, classify proc_data_in (the data for the current proc_addr_in) and increment the matching accumulator.
  - If proc_addr_in==IMA_SIZE-1: go to DECIDE and set proc_addr_in<=PARK_ADDR. Otherwise proc_addr_in<=proc_addr_in+1.
  - Pixel k is sampled at edge E0+1+k. The last pixel is sampled at E0+IMA_SIZE.
- DECIDE (one cycle):
  - Copy the accumulators to cnt_r/cnt_g/cnt_b.
  - Compute color: the maximum of the three counts, with ties resolved red > green > blue.
  - If that maximum is < MIN_PIX, color=00.
  - busy<=0, done<=1, go to DONE. Done rises at edge E0+IMA_SIZE+1 (E0+19201 by default).
- DONE (one cycle): done<=0, go to IDLE.
- init is ignored in SCAN, DECIDE and DONE. It is not queued.
- init held high continuously restarts a scan on the first IDLE cycle after DONE.
- Accumulators are 15 bits. The maximum possible count is 19200 < 2^15, so no overflow or saturation logic is needed.
- Outputs color and cnt_* hold their values until the next DECIDE or a reset. A new scan does not clear them early.

Test Plan:
- Reset, then check every output. Expected: busy=0, done=0, color=00, counts 0, proc_addr_in=7FFF.
- Frame all 12'hF00, pulse init at E0.
  - Expected: proc_addr_in steps 0..19199, busy high for 19201 cycles.
  - Expected: done high exactly at E0+19201 for one cycle.
  - Expected: cnt_r=19200, cnt_g=0, cnt_b=0, color=01.
- Frame with 5000 px of 0F0, 4000 px of 00F, rest 000.
  - Expected: cnt_g=5000, cnt_b=4000, cnt_r=0, color=10.
- Frame with 3000 px of F00, 3000 px of 0F0, and 1000 ambiguous px (e.g. 880, F0F, 444).
  - Expected: cnt_r=3000, cnt_g=3000, cnt_b=0, color=01 (tie priority; ambiguous pixels uncounted).
- Frame with 1000 px of 00F only.
  - Expected: cnt_b=1000, color=00 (below MIN_PIX).
- Assert rst at scan cycle 5000, then re-init on an all-blue frame.
  - Expected: immediate clear and no done pulse during reset.
  - Expected: second scan gives cnt_b=19200, color=11.
  - Also check: an extra init pulse mid-scan causes no restart and no timing change.

Source files
------------

// File: rtl/color_detect_proc.sv
// Colour detection stage for a stored RGB444 frame.
//
// On an init request the block walks the frame buffer's processing port from
// address 0 to IMA_SIZE-1, one pixel per clock, and classifies every pixel as
// red, green, blue or none. After the last pixel it publishes the per-colour
// counts and the dominant colour, and pulses done for one cycle.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   init          start request, sampled at posedge (ignored while not idle)
//   proc_addr_in  pixel address to the buffer (PARK_ADDR while not scanning)
//   proc_data_in  pixel data, combinational in proc_addr_in
//   busy          high while a scan is in progress
//   done          one-cycle pulse when results are valid
//   color         dominant colour: 00 none, 01 red, 10 green, 11 blue
//   cnt_r/g/b     per-colour counts of the last completed scan
module color_detect_proc #(
  parameter int unsigned    AW        = 15,
  parameter int unsigned    DW        = 12,
  parameter int unsigned    IMA_SIZE  = 19200,
  parameter logic [3:0]     TH_HI     = 4'd8,
  parameter logic [3:0]     TH_LO     = 4'd5,
  parameter int unsigned    MIN_PIX   = 1920,
  parameter logic [AW-1:0]  PARK_ADDR = 15'h7FFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  output logic [AW-1:0] proc_addr_in,
  input  logic [DW-1:0] proc_data_in,
  output logic          busy,
  output logic          done,
  output logic [1:0]    color,
  output logic [14:0]   cnt_r,
  output logic [14:0]   cnt_g,
  output logic [14:0]   cnt_b
);

  localparam int unsigned CW = 15;
  localparam logic [AW-1:0] LastAddr = AW'(IMA_SIZE - 1);
  localparam logic [CW-1:0] MinPix   = CW'(MIN_PIX);

  typedef enum logic [1:0] {StIdle, StScan, StDecide, StDone} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [1:0]     color_q, color_d;
  logic [CW-1:0]  cnt_r_q, cnt_r_d, cnt_g_q, cnt_g_d, cnt_b_q, cnt_b_d;
  logic [CW-1:0]  acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;

  // Pixel classification
  logic [3:0] ch_r, ch_g, ch_b;
  logic       is_r, is_g, is_b;

  assign ch_r = proc_data_in[DW-1 -: 4];
  assign ch_g = proc_data_in[DW-5 -: 4];
  assign ch_b = proc_data_in[DW-9 -: 4];

  assign is_r = (ch_r >= TH_HI) && (ch_g < TH_LO) && (ch_b < TH_LO);
  assign is_g = (ch_g >= TH_HI) && (ch_r < TH_LO) && (ch_b < TH_LO);
  assign is_b = (ch_b >= TH_HI) && (ch_r < TH_LO) && (ch_g < TH_LO);

  // Dominant colour from the finished accumulators; ties favour red, then green.
  logic [1:0]    win;
  logic [CW-1:0] max_cnt;

  always_comb begin
    win     = 2'b00;
    max_cnt = '0;
    if ((acc_r_q >= acc_g_q) && (acc_r_q >= acc_b_q)) begin
      win     = 2'b01;
      max_cnt = acc_r_q;
    end else if (acc_g_q >= acc_b_q) begin
      win     = 2'b10;
      max_cnt = acc_g_q;
    end else begin
      win     = 2'b11;
      max_cnt = acc_b_q;
    end
    if (max_cnt < MinPix) begin
      win = 2'b00;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    color_d = color_q;
    cnt_r_d = cnt_r_q;
    cnt_g_d = cnt_g_q;
    cnt_b_d = cnt_b_q;
    acc_r_d = acc_r_q;
    acc_g_d = acc_g_q;
    acc_b_d = acc_b_q;

    unique case (state_q)
      StIdle: begin
        addr_d = PARK_ADDR;
        if (init) begin
          state_d = StScan;
          addr_d  = '0;
          acc_r_d = '0;
          acc_g_d = '0;
          acc_b_d = '0;
          busy_d  = 1'b1;
        end
      end
      StScan: begin
        if (is_r) acc_r_d = acc_r_q + CW'(1);
        if (is_g) acc_g_d = acc_g_q + CW'(1);
        if (is_b) acc_b_d = acc_b_q + CW'(1);
        if (addr_q == LastAddr) begin
          state_d = StDecide;
          addr_d  = PARK_ADDR;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      StDecide: begin
        cnt_r_d = acc_r_q;
        cnt_g_d = acc_g_q;
        cnt_b_d = acc_b_q;
        color_d = win;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        addr_d  = PARK_ADDR;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= PARK_ADDR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      color_q <= 2'b00;
      cnt_r_q <= '0;
      cnt_g_q <= '0;
      cnt_b_q <= '0;
      acc_r_q <= '0;
      acc_g_q <= '0;
      acc_b_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      color_q <= color_d;
      cnt_r_q <= cnt_r_d;
      cnt_g_q <= cnt_g_d;
      cnt_b_q <= cnt_b_d;
      acc_r_q <= acc_r_d;
      acc_g_q <= acc_g_d;
      acc_b_q <= acc_b_d;
    end
  end

  assign proc_addr_in = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign color        = color_q;
  assign cnt_r        = cnt_r_q;
  assign cnt_g        = cnt_g_q;
  assign cnt_b        = cnt_b_q;

endmodule

// File: tb/tb_color_detect_proc.sv
// Directed bench for color_detect_proc. Two instances with independent frame
// memories share clock and reset so that two full-frame scans run side by side.
module tb_color_detect_proc;

  localparam int NPIX = 19200;
  localparam int PARK = 32767;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init0 = 1'b0, init1 = 1'b0;
  logic [14:0] addr0, addr1;
  logic [11:0] data0, data1;
  logic        busy0, busy1, done0, done1;
  logic [1:0]  color0, color1;
  logic [14:0] cr0, cg0, cb0, cr1, cg1, cb1;

  logic [11:0] mem0 [32768];
  logic [11:0] mem1 [32768];

  assign data0 = mem0[addr0];
  assign data1 = mem1[addr1];

  always #5 clk = ~clk;

  color_detect_proc u_dut0 (
    .clk(clk), .rst(rst), .init(init0), .proc_addr_in(addr0), .proc_data_in(data0),
    .busy(busy0), .done(done0), .color(color0), .cnt_r(cr0), .cnt_g(cg0), .cnt_b(cb0)
  );

  color_detect_proc u_dut1 (
    .clk(clk), .rst(rst), .init(init1), .proc_addr_in(addr1), .proc_data_in(data1),
    .busy(busy1), .done(done1), .color(color1), .cnt_r(cr1), .cnt_g(cg1), .cnt_b(cb1)
  );

  int checks = 0;
  int errors = 0;

  // Per-instance scan observations
  int done_at [2];
  int done_cnt [2];
  int busy_cyc [2];
  int addr_err [2];
  int hold_r [2];
  int hold_g [2];
  int hold_b [2];
  int hold_c [2];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int which, input int lo, input int hi, input logic [11:0] v);
    for (int k = lo; k <= hi; k++) begin
      if (which == 0) mem0[k] = v;
      else mem1[k] = v;
    end
  endtask

  // Pulse init on the selected instances at edge E0 and watch until well past done.
  // Sample n is taken 1 time unit after edge E0+n.
  task automatic run_pair(input bit go0, input bit go1, input bit mid_init);
    for (int i = 0; i < 2; i++) begin
      done_at[i] = -1; done_cnt[i] = 0; busy_cyc[i] = 0; addr_err[i] = 0;
    end
    @(negedge clk);
    init0 = go0;
    init1 = go1;
    for (int n = 0; n <= NPIX + 8; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) begin
        init0 = 1'b0;
        init1 = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        logic b, d;
        logic [14:0] a;
        int exp_a;
        b = (i == 0) ? busy0 : busy1;
        d = (i == 0) ? done0 : done1;
        a = (i == 0) ? addr0 : addr1;
        exp_a = (n <= NPIX - 1) ? n : PARK;
        if (b) busy_cyc[i]++;
        if (d) begin
          done_cnt[i]++;
          if (done_at[i] < 0) done_at[i] = n;
        end
        if (int'(a) != exp_a) addr_err[i]++;
        if (n == 100) begin
          hold_r[i] = (i == 0) ? int'(cr0) : int'(cr1);
          hold_g[i] = (i == 0) ? int'(cg0) : int'(cg1);
          hold_b[i] = (i == 0) ? int'(cb0) : int'(cb1);
          hold_c[i] = (i == 0) ? int'(color0) : int'(color1);
        end
      end
      // Extra start request in the middle of a scan must be ignored.
      if (mid_init && n == 100) init0 = 1'b1;
      if (mid_init && n == 101) init0 = 1'b0;
    end
  endtask

  initial begin
    fill(0, 0, PARK, 12'h000);
    fill(1, 0, PARK, 12'h000);

    // Reset state, while reset is held and after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_color", int'(color0), 0);
    chk("rst_cnts", int'(cr0) + int'(cg0) + int'(cb0), 0);
    chk("rst_addr", int'(addr0), PARK);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_addr", int'(addr0), PARK);
    chk("idle_busy", int'(busy0), 0);

    // Inst0: all red, with a stray init mid-scan. Inst1: 5000 green, 4000 blue.
    fill(0, 0, NPIX - 1, 12'hF00);
    fill(1, 0, 4999, 12'h0F0);
    fill(1, 5000, 8999, 12'h00F);
    run_pair(1'b1, 1'b1, 1'b1);
    chk("red_done_at", done_at[0], NPIX + 1);
    chk("red_done_len", done_cnt[0], 1);
    chk("red_busy_cyc", busy_cyc[0], NPIX + 1);
    chk("red_addr_seq", addr_err[0], 0);
    chk("red_cnt_r", int'(cr0), NPIX);
    chk("red_cnt_g", int'(cg0), 0);
    chk("red_cnt_b", int'(cb0), 0);
    chk("red_color", int'(color0), 1);
    chk("gb_done_at", done_at[1], NPIX + 1);
    chk("gb_addr_seq", addr_err[1], 0);
    chk("gb_cnt_r", int'(cr1), 0);
    chk("gb_cnt_g", int'(cg1), 5000);
    chk("gb_cnt_b", int'(cb1), 4000);
    chk("gb_color", int'(color1), 2);

    // Inst0: red/green tie plus ambiguous pixels. Inst1: 1000 blue only.
    fill(0, 0, PARK, 12'h000);
    fill(0, 0, 2999, 12'hF00);
    fill(0, 3000, 5999, 12'h0F0);
    for (int k = 6000; k < 7000; k++)
      mem0[k] = (k % 3 == 0) ? 12'h880 : ((k % 3 == 1) ? 12'hF0F : 12'h444);
    fill(1, 0, PARK, 12'h000);
    fill(1, 0, 999, 12'h00F);
    run_pair(1'b1, 1'b1, 1'b0);
    // Previous results must still be visible early in the new scan.
    chk("hold_r0", hold_r[0], NPIX);
    chk("hold_c0", hold_c[0], 1);
    chk("hold_g1", hold_g[1], 5000);
    chk("hold_b1", hold_b[1], 4000);
    chk("hold_c1", hold_c[1], 2);
    chk("tie_done_at", done_at[0], NPIX + 1);
    chk("tie_cnt_r", int'(cr0), 3000);
    chk("tie_cnt_g", int'(cg0), 3000);
    chk("tie_cnt_b", int'(cb0), 0);
    chk("tie_color", int'(color0), 1);
    chk("few_cnt_b", int'(cb1), 1000);
    chk("few_cnt_rg", int'(cr1) + int'(cg1), 0);
    chk("few_color", int'(color1), 0);

    // Reset in the middle of a scan on inst0
    @(negedge clk);
    init0 = 1'b1;
    @(posedge clk);
    #1;
    init0 = 1'b0;
    repeat (5000) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy0), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_addr", int'(addr0), PARK);
    chk("mid_rst_color", int'(color0), 0);
    chk("mid_rst_cnts", int'(cr0) + int'(cg0) + int'(cb0), 0);
    chk("mid_rst_cnt_b1", int'(cb1), 0);
    begin
      int seen_done;
      seen_done = 0;
      fill(0, 0, NPIX - 1, 12'h00F);
      for (int n = 0; n < 4; n++) begin
        @(posedge clk);
        #1;
        if (done0) seen_done++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
        @(posedge clk);
        #1;
        if (done0 || busy0) seen_done++;
      end
      chk("mid_rst_no_done", seen_done, 0);
    end

    // Fresh scan of an all-blue frame after the abort
    run_pair(1'b1, 1'b0, 1'b0);
    chk("blue_done_at", done_at[0], NPIX + 1);
    chk("blue_busy_cyc", busy_cyc[0], NPIX + 1);
    chk("blue_cnt_b", int'(cb0), NPIX);
    chk("blue_cnt_rg", int'(cr0) + int'(cg0), 0);
    chk("blue_color", int'(color0), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
